// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared command encoding and default parameters for the program counter sequencer
package pc_pkg;

    typedef enum logic [2:0] {
        CMD_NONE,
        CMD_INC,
        CMD_BRANCH,
        CMD_CALL,
        CMD_RET,
        CMD_SET
    } cmd_e;

    localparam int DEF_ADDR_W      = 8;
    localparam int DEF_OFF_W       = 8;
    localparam int DEF_STACK_DEPTH = 4;
    localparam int DEF_RESET_ADDR  = 0;

endpackage

// File: rtl/pc_ras.sv
// rtl/pc_ras.sv - return-address stack: LIFO storage with depth counter
module pc_ras
    import pc_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int STACK_DEPTH = DEF_STACK_DEPTH,
    localparam int DEPTH_W    = $clog2(STACK_DEPTH + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               push,
    input  logic               pop,
    input  logic [ADDR_W-1:0]  push_data,
    output logic [ADDR_W-1:0]  top,
    output logic [DEPTH_W-1:0] depth,
    output logic               full,
    output logic               empty
);

    logic [ADDR_W-1:0]  stack_q [STACK_DEPTH];
    logic [ADDR_W-1:0]  stack_d [STACK_DEPTH];
    logic [DEPTH_W-1:0] depth_q;
    logic [DEPTH_W-1:0] depth_d;

    assign depth = depth_q;
    assign empty = (depth_q == '0);
    assign full  = (depth_q == DEPTH_W'(STACK_DEPTH));

    // Index by comparison so a single-entry stack needs no zero-width pointer
    always_comb begin
        top = '0;
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (DEPTH_W'(i + 1) == depth_q) top = stack_q[i];
        end
    end

    always_comb begin
        stack_d = stack_q;
        depth_d = depth_q;
        if (push && !full) begin
            for (int i = 0; i < STACK_DEPTH; i++) begin
                if (DEPTH_W'(i) == depth_q) stack_d[i] = push_data;
            end
            depth_d = depth_q + DEPTH_W'(1);
        end else if (pop && !empty) begin
            depth_d = depth_q - DEPTH_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < STACK_DEPTH; i++) stack_q[i] <= '0;
            depth_q <= '0;
        end else begin
            stack_q <= stack_d;
            depth_q <= depth_d;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program counter with priority command decode and return-address stack
// PC_STICKY_ERR_EN: sticky overflow/underflow flags with err_clr input.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int OFF_W       = DEF_OFF_W,
    parameter int STACK_DEPTH = DEF_STACK_DEPTH,
    parameter int RESET_ADDR  = DEF_RESET_ADDR
) (
    input  logic                               clk,
    input  logic                               reset,
`ifdef PC_STICKY_ERR_EN
    input  logic                               err_clr,
`endif
    input  logic                               increment,
    input  logic                               set,
    input  logic                               branch,
    input  logic                               call,
    input  logic                               ret,
    input  logic [ADDR_W-1:0]                  new_count,
    input  logic [OFF_W-1:0]                   offset,
    output logic [ADDR_W-1:0]                  count,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   depth,
    output logic                               empty,
    output logic                               full,
    output logic                               overflow,
    output logic                               underflow
);

    cmd_e              cmd;
    logic [ADDR_W-1:0] count_q, count_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;
    logic              ovf_evt, unf_evt;
    logic              ras_push, ras_pop;
    logic [ADDR_W-1:0] ras_top;
    logic [ADDR_W-1:0] off_ext;
    logic [ADDR_W-1:0] count_inc;

    assign count     = count_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;
    assign off_ext   = ADDR_W'($signed(offset));
    assign count_inc = count_q + ADDR_W'(1);

    always_comb begin
        cmd = CMD_NONE;
        if (set)            cmd = CMD_SET;
        else if (ret)       cmd = CMD_RET;
        else if (call)      cmd = CMD_CALL;
        else if (branch)    cmd = CMD_BRANCH;
        else if (increment) cmd = CMD_INC;
    end

    always_comb begin
        count_d  = count_q;
        ovf_evt  = 1'b0;
        unf_evt  = 1'b0;
        ras_push = 1'b0;
        ras_pop  = 1'b0;
        case (cmd)
            CMD_SET:    count_d = new_count;
            CMD_RET: begin
                if (empty) begin
                    unf_evt = 1'b1;
                end else begin
                    ras_pop = 1'b1;
                    count_d = ras_top;
                end
            end
            // A call while full still jumps; only the return address is lost
            CMD_CALL: begin
                count_d = new_count;
                if (full) ovf_evt  = 1'b1;
                else      ras_push = 1'b1;
            end
            CMD_BRANCH: count_d = count_q + off_ext;
            CMD_INC:    count_d = count_inc;
            default:    count_d = count_q;
        endcase
`ifdef PC_STICKY_ERR_EN
        overflow_d  = ovf_evt | (overflow_q & ~err_clr);
        underflow_d = unf_evt | (underflow_q & ~err_clr);
`else
        overflow_d  = ovf_evt;
        underflow_d = unf_evt;
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q     <= ADDR_W'(RESET_ADDR);
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    pc_ras #(
        .ADDR_W      (ADDR_W),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_ras (
        .clk       (clk),
        .reset     (reset),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (count_inc),
        .top       (ras_top),
        .depth     (depth),
        .full      (full),
        .empty     (empty)
    );

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed self-checking bench for pc_sequencer
module tb_pc_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       increment, set, branch, call, ret;
    logic [7:0] new_count, offset;
    logic [7:0] count;
    logic [2:0] depth;
    logic       empty, full, overflow, underflow;
`ifdef PC_STICKY_ERR_EN
    logic       err_clr = 1'b0;
`endif

    int n_checks = 0;
    int n_errors = 0;

    pc_sequencer #(
        .ADDR_W      (8),
        .OFF_W       (8),
        .STACK_DEPTH (4),
        .RESET_ADDR  (0)
    ) dut (
        .clk       (clk),
        .reset     (reset),
`ifdef PC_STICKY_ERR_EN
        .err_clr   (err_clr),
`endif
        .increment (increment),
        .set       (set),
        .branch    (branch),
        .call      (call),
        .ret       (ret),
        .new_count (new_count),
        .offset    (offset),
        .count     (count),
        .depth     (depth),
        .empty     (empty),
        .full      (full),
        .overflow  (overflow),
        .underflow (underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_cmd(input logic i_inc, i_set, i_br, i_call, i_ret,
                          input logic [7:0] nc, off);
        increment = i_inc;
        set       = i_set;
        branch    = i_br;
        call      = i_call;
        ret       = i_ret;
        new_count = nc;
        offset    = off;
        cyc();
        increment = 1'b0;
        set       = 1'b0;
        branch    = 1'b0;
        call      = 1'b0;
        ret       = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        increment = 1'b0; set = 1'b0; branch = 1'b0; call = 1'b0; ret = 1'b0;
        new_count = '0; offset = '0;
        cyc(); cyc();
        check("rst_count", count, 8'h00);
        check("rst_depth", depth, 3'd0);
        check("rst_empty", empty, 1'b1);
        check("rst_full", full, 1'b0);
        check("rst_ovf", overflow, 1'b0);
        check("rst_unf", underflow, 1'b0);
        reset = 1'b1;

        // 1: asynchronous reset mid-run
        do_cmd(0, 0, 0, 1, 0, 8'h30, 8'h00);
        do_cmd(0, 0, 0, 1, 0, 8'h37, 8'h00);
        check("pre_rst_count", count, 8'h37);
        check("pre_rst_depth", depth, 3'd2);
        reset = 1'b0;
        #1;
        check("async_rst_count", count, 8'h00);
        check("async_rst_depth", depth, 3'd0);
        #2 reset = 1'b1;
        repeat (3) do_cmd(1, 0, 0, 0, 0, 8'h00, 8'h00);
        check("inc3_count", count, 8'h03);
        cyc();
        check("idle_hold", count, 8'h03);

        // 2: wrap-around arithmetic
        do_cmd(0, 1, 0, 0, 0, 8'hFF, 8'h00);
        do_cmd(1, 0, 0, 0, 0, 8'h00, 8'h00);
        check("inc_wrap", count, 8'h00);
        do_cmd(0, 1, 0, 0, 0, 8'h10, 8'h00);
        do_cmd(0, 0, 1, 0, 0, 8'h00, 8'hF0);
        check("branch_neg", count, 8'h00);
        do_cmd(0, 1, 0, 0, 0, 8'hF8, 8'h00);
        do_cmd(0, 0, 1, 0, 0, 8'h00, 8'h10);
        check("branch_wrap", count, 8'h08);

        // 3: nested call / return
        do_cmd(0, 1, 0, 0, 0, 8'h05, 8'h00);
        do_cmd(0, 0, 0, 1, 0, 8'h40, 8'h00);
        check("call1_count", count, 8'h40);
        check("call1_depth", depth, 3'd1);
        do_cmd(0, 0, 0, 1, 0, 8'h80, 8'h00);
        check("call2_count", count, 8'h80);
        check("call2_depth", depth, 3'd2);
        do_cmd(0, 0, 0, 0, 1, 8'h00, 8'h00);
        check("ret1_count", count, 8'h41);
        do_cmd(0, 0, 0, 0, 1, 8'h00, 8'h00);
        check("ret2_count", count, 8'h06);
        check("ret2_empty", empty, 1'b1);

        // 4: overflow and underflow
        do_cmd(0, 0, 0, 1, 0, 8'h10, 8'h00);
        do_cmd(0, 0, 0, 1, 0, 8'h20, 8'h00);
        do_cmd(0, 0, 0, 1, 0, 8'h30, 8'h00);
        do_cmd(0, 0, 0, 1, 0, 8'h40, 8'h00);
        check("fill_depth", depth, 3'd4);
        check("fill_full", full, 1'b1);
        check("fill_ovf", overflow, 1'b0);
        do_cmd(0, 0, 0, 1, 0, 8'h50, 8'h00);
        check("ovf_count", count, 8'h50);
        check("ovf_depth", depth, 3'd4);
        check("ovf_pulse", overflow, 1'b1);
        cyc();
`ifdef PC_STICKY_ERR_EN
        check("ovf_sticky", overflow, 1'b1);
        err_clr = 1'b1;
        cyc();
        err_clr = 1'b0;
        check("ovf_cleared", overflow, 1'b0);
`else
        check("ovf_drop", overflow, 1'b0);
`endif
        do_cmd(0, 0, 0, 0, 1, 8'h00, 8'h00);
        check("pop4_a", count, 8'h31);
        do_cmd(0, 0, 0, 0, 1, 8'h00, 8'h00);
        check("pop4_b", count, 8'h21);
        do_cmd(0, 0, 0, 0, 1, 8'h00, 8'h00);
        check("pop4_c", count, 8'h11);
        do_cmd(0, 0, 0, 0, 1, 8'h00, 8'h00);
        check("pop4_d", count, 8'h07);
        check("pop4_empty", empty, 1'b1);
        do_cmd(0, 0, 0, 0, 1, 8'h00, 8'h00);
        check("unf_count", count, 8'h07);
        check("unf_pulse", underflow, 1'b1);
`ifdef PC_STICKY_ERR_EN
        // 6: sticky flags
        for (int i = 0; i < 10; i++) begin
            cyc();
            check("unf_sticky", underflow, 1'b1);
        end
        err_clr = 1'b1;
        cyc();
        check("unf_cleared", underflow, 1'b0);
        do_cmd(0, 0, 0, 0, 1, 8'h00, 8'h00);
        check("unf_err_wins", underflow, 1'b1);
        cyc();
        err_clr = 1'b0;
        check("unf_cleared2", underflow, 1'b0);
`else
        cyc();
        check("unf_drop", underflow, 1'b0);
`endif

        // 5: strobe priority
        do_cmd(0, 0, 0, 1, 0, 8'h60, 8'h00);
        check("prio_setup_depth", depth, 3'd1);
        do_cmd(1, 1, 0, 0, 1, 8'h22, 8'h00);
        check("prio_set_count", count, 8'h22);
        check("prio_set_depth", depth, 3'd1);
        do_cmd(0, 0, 1, 1, 0, 8'h90, 8'h05);
        check("prio_call_count", count, 8'h90);
        check("prio_call_depth", depth, 3'd2);
        do_cmd(0, 0, 0, 1, 1, 8'hAA, 8'h00);
        check("prio_ret_count", count, 8'h23);
        check("prio_ret_depth", depth, 3'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
